// File: rtl/seq_pkg.sv
// Shared types and constants for the Padovan sequence checker and its companion benches.
package seq_pkg;

  typedef enum logic [1:0] {
    ACQ0  = 2'd0,
    ACQ1  = 2'd1,
    ACQ2  = 2'd2,
    CHECK = 2'd3
  } seq_state_e;

  // Seed terms P(0), P(1), P(2) that the generator starts from.
  localparam int unsigned PAD_INIT0 = 0;
  localparam int unsigned PAD_INIT1 = 1;
  localparam int unsigned PAD_INIT2 = 1;

endpackage

// File: rtl/seq_term_calc.sv
// Three-deep term history plus the next-term adders used by the checker.
module seq_term_calc #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_clear,
  input  logic          i_shift,
  input  logic          i_load_pred,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_pred,
  output logic [DW-1:0] o_pred_next
);

  logic [DW-1:0] r_h1;
  logic [DW-1:0] r_h2;
  logic [DW-1:0] r_h3;
  logic [DW-1:0] w_load;

  assign o_pred      = r_h2 + r_h3;
  // Prediction that becomes valid after the next shift; independent of the loaded term.
  assign o_pred_next = r_h1 + r_h2;
  assign w_load      = i_load_pred ? o_pred : i_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h1 <= '0;
      r_h2 <= '0;
      r_h3 <= '0;
    end else if (i_clear) begin
      r_h1 <= '0;
      r_h2 <= '0;
      r_h3 <= '0;
    end else if (i_shift) begin
      r_h1 <= w_load;
      r_h2 <= r_h1;
      r_h3 <= r_h2;
    end
  end

endmodule

// File: rtl/seq_checker.sv
// Padovan stream checker: acquires three terms, then predicts and checks every following beat.
//   state | meaning
//   ACQ0  | waiting for first history term
//   ACQ1  | waiting for second history term
//   ACQ2  | waiting for third history term
//   CHECK | locked, every beat compared against prediction
module seq_checker
  import seq_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             seq_vld_i,
  input  logic [DW-1:0]    seq_i,
  output logic             locked_o,
  output logic             mismatch_o,
  output logic             err_sticky_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] term_cnt_o,
  output logic [CNT_W-1:0] first_err_idx_o,
  output logic [DW-1:0]    exp_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_e       r_state;
  logic             r_locked;
  logic             r_mismatch;
  logic             r_err_sticky;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_term_cnt;
  logic [CNT_W-1:0] r_first_err_idx;
  logic [DW-1:0]    r_exp;

  logic             w_beat;
  logic             w_bad;
  logic [DW-1:0]    w_pred;
  logic [DW-1:0]    w_pred_next;

  assign w_beat = seq_vld_i & ~clear_i;
  assign w_bad  = w_beat & (r_state == CHECK) & (seq_i != w_pred);

  // A bad term is replaced by its prediction so one corruption is counted only once.
  seq_term_calc #(
    .DW (DW)
  ) u_term_calc (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (clear_i),
    .i_shift     (w_beat),
    .i_load_pred (w_bad),
    .i_data      (seq_i),
    .o_pred      (w_pred),
    .o_pred_next (w_pred_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ACQ0;
      r_locked        <= 1'b0;
      r_mismatch      <= 1'b0;
      r_err_sticky    <= 1'b0;
      r_err_cnt       <= '0;
      r_term_cnt      <= '0;
      r_first_err_idx <= '0;
      r_exp           <= '0;
    end else if (clear_i) begin
      r_state         <= ACQ0;
      r_locked        <= 1'b0;
      r_mismatch      <= 1'b0;
      r_err_sticky    <= 1'b0;
      r_err_cnt       <= '0;
      r_term_cnt      <= '0;
      r_first_err_idx <= '0;
      r_exp           <= '0;
    end else begin
      r_mismatch <= 1'b0;
      if (seq_vld_i) begin
        if (r_term_cnt != CNT_MAX) r_term_cnt <= r_term_cnt + 1'b1;
        case (r_state)
          ACQ0: r_state <= ACQ1;
          ACQ1: r_state <= ACQ2;
          ACQ2: begin
            r_state  <= CHECK;
            r_locked <= 1'b1;
            r_exp    <= w_pred_next;
          end
          CHECK: begin
            r_exp <= w_pred_next;
            if (w_bad) begin
              r_mismatch   <= 1'b1;
              r_err_sticky <= 1'b1;
              if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
              // Pre-increment term count is the 0-based index of this beat.
              if (!r_err_sticky) r_first_err_idx <= r_term_cnt;
            end
          end
          default: r_state <= ACQ0;
        endcase
      end
    end
  end

  assign locked_o        = r_locked;
  assign mismatch_o      = r_mismatch;
  assign err_sticky_o    = r_err_sticky;
  assign err_cnt_o       = r_err_cnt;
  assign term_cnt_o      = r_term_cnt;
  assign first_err_idx_o = r_first_err_idx;
  assign exp_o           = r_exp;

endmodule

// File: tb/tb_seq_checker.sv
// Directed bench for seq_checker: 32-bit default instance, an 8-bit wrap instance and a 4-bit counter instance.
module tb_seq_checker;
  import seq_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        clear = 1'b0, vld = 1'b0;
  logic [31:0] seq = '0;
  logic        locked, mism, sticky;
  logic [15:0] err_cnt, term_cnt, first_idx;
  logic [31:0] exp_v;

  logic        clear8 = 1'b0, vld8 = 1'b0;
  logic [7:0]  seq8 = '0;
  logic        locked8, mism8, sticky8;
  logic [15:0] err8, term8, idx8;
  logic [7:0]  exp8;

  logic        clear4 = 1'b0, vld4 = 1'b0;
  logic [31:0] seq4 = '0;
  logic        locked4, mism4, sticky4;
  logic [3:0]  err4, term4, idx4;
  logic [31:0] exp4;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] pad32 [0:31];
  logic [7:0]  pad8  [0:255];

  seq_checker #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clear_i(clear), .seq_vld_i(vld), .seq_i(seq),
    .locked_o(locked), .mismatch_o(mism), .err_sticky_o(sticky), .err_cnt_o(err_cnt),
    .term_cnt_o(term_cnt), .first_err_idx_o(first_idx), .exp_o(exp_v));

  seq_checker #(.DW(8), .CNT_W(16)) dut8 (
    .clk(clk), .reset(reset), .clear_i(clear8), .seq_vld_i(vld8), .seq_i(seq8),
    .locked_o(locked8), .mismatch_o(mism8), .err_sticky_o(sticky8), .err_cnt_o(err8),
    .term_cnt_o(term8), .first_err_idx_o(idx8), .exp_o(exp8));

  seq_checker #(.DW(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .clear_i(clear4), .seq_vld_i(vld4), .seq_i(seq4),
    .locked_o(locked4), .mismatch_o(mism4), .err_sticky_o(sticky4), .err_cnt_o(err4),
    .term_cnt_o(term4), .first_err_idx_o(idx4), .exp_o(exp4));

  task automatic drive(input logic v, input logic [31:0] d);
    @(negedge clk);
    vld = v;
    seq = d;
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic v, input logic [31:0] d);
    @(negedge clk);
    vld4 = v;
    seq4 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", locked); else n_pass++;
    n_total++; if (mism !== 1'b0) $display("FAIL reset_mismatch: got %0b want 0", mism); else n_pass++;
    n_total++; if (sticky !== 1'b0) $display("FAIL reset_sticky: got %0b want 0", sticky); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (term_cnt !== 16'd0) $display("FAIL reset_term_cnt: got %0d want 0", term_cnt); else n_pass++;
    n_total++; if (first_idx !== 16'd0) $display("FAIL reset_first_idx: got %0d want 0", first_idx); else n_pass++;
    n_total++; if (exp_v !== 32'd0) $display("FAIL reset_exp: got %0d want 0", exp_v); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic seen_mm;
    seen_mm = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, pad32[i]);
      if (mism !== 1'b0) seen_mm = 1'b1;
      if (i == 1) begin
        n_total++; if (locked !== 1'b0) $display("FAIL basic_unlocked_2beats: got %0b want 0", locked); else n_pass++;
        n_total++; if (exp_v !== 32'd0) $display("FAIL basic_exp_unlocked: got %0d want 0", exp_v); else n_pass++;
      end
      if (i == 2) begin
        n_total++; if (locked !== 1'b1) $display("FAIL basic_locked_3beats: got %0b want 1", locked); else n_pass++;
        n_total++; if (exp_v !== 32'd1) $display("FAIL basic_exp_first: got %0d want 1", exp_v); else n_pass++;
      end
    end
    drive(1'b0, 32'd0);
    n_total++; if (seen_mm !== 1'b0) $display("FAIL basic_no_mismatch: got %0b want 0", seen_mm); else n_pass++;
    n_total++; if (term_cnt !== 16'd10) $display("FAIL basic_term_cnt: got %0d want 10", term_cnt); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL basic_err_cnt: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (exp_v !== 32'd9) $display("FAIL basic_exp_p10: got %0d want 9", exp_v); else n_pass++;
    n_total++; if (sticky !== 1'b0) $display("FAIL basic_sticky: got %0b want 0", sticky); else n_pass++;
  endtask

  task automatic test_corrupt();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1;
    n_total++; if (term_cnt !== 16'd0) $display("FAIL corrupt_clear_term: got %0d want 0", term_cnt); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL corrupt_clear_locked: got %0b want 0", locked); else n_pass++;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i == 6) ? 32'd8 : pad32[i]);
      if (i == 6) begin
        n_total++; if (mism !== 1'b1) $display("FAIL corrupt_pulse: got %0b want 1", mism); else n_pass++;
        n_total++; if (err_cnt !== 16'd1) $display("FAIL corrupt_err_cnt: got %0d want 1", err_cnt); else n_pass++;
        n_total++; if (first_idx !== 16'd6) $display("FAIL corrupt_first_idx: got %0d want 6", first_idx); else n_pass++;
        n_total++; if (sticky !== 1'b1) $display("FAIL corrupt_sticky: got %0b want 1", sticky); else n_pass++;
      end
      if (i == 7) begin
        n_total++; if (mism !== 1'b0) $display("FAIL corrupt_pulse_width: got %0b want 0", mism); else n_pass++;
      end
    end
    drive(1'b0, 32'd0);
    n_total++; if (err_cnt !== 16'd1) $display("FAIL corrupt_no_cascade: got %0d want 1", err_cnt); else n_pass++;
    n_total++; if (term_cnt !== 16'd10) $display("FAIL corrupt_term_cnt: got %0d want 10", term_cnt); else n_pass++;
    n_total++; if (exp_v !== 32'd9) $display("FAIL corrupt_exp_recovered: got %0d want 9", exp_v); else n_pass++;
    n_total++; if (first_idx !== 16'd6) $display("FAIL corrupt_idx_held: got %0d want 6", first_idx); else n_pass++;
  endtask

  task automatic test_clear_with_beat();
    @(negedge clk);
    clear = 1'b1;
    vld = 1'b1;
    seq = pad32[0];
    @(posedge clk);
    #1;
    n_total++; if (term_cnt !== 16'd0) $display("FAIL clrbeat_term: got %0d want 0", term_cnt); else n_pass++;
    n_total++; if (locked !== 1'b0) $display("FAIL clrbeat_locked: got %0b want 0", locked); else n_pass++;
    n_total++; if (sticky !== 1'b0) $display("FAIL clrbeat_sticky: got %0b want 0", sticky); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL clrbeat_err: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (first_idx !== 16'd0) $display("FAIL clrbeat_idx: got %0d want 0", first_idx); else n_pass++;
    n_total++; if (exp_v !== 32'd0) $display("FAIL clrbeat_exp: got %0d want 0", exp_v); else n_pass++;
    @(negedge clk);
    clear = 1'b0;
    vld = 1'b0;
    drive(1'b1, pad32[0]);
    drive(1'b1, pad32[1]);
    n_total++; if (locked !== 1'b0) $display("FAIL clrbeat_relock_early: got %0b want 0", locked); else n_pass++;
    drive(1'b1, pad32[2]);
    n_total++; if (locked !== 1'b1) $display("FAIL clrbeat_relock: got %0b want 1", locked); else n_pass++;
    n_total++; if (term_cnt !== 16'd3) $display("FAIL clrbeat_relock_term: got %0d want 3", term_cnt); else n_pass++;
    drive(1'b0, 32'd0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, pad32[3]);
    drive(1'b1, pad32[4]);
    drive(1'b1, 32'd99);
    drive(1'b0, 32'd0);
    n_total++; if (err_cnt !== 16'd1) $display("FAIL areset_pre_err: got %0d want 1", err_cnt); else n_pass++;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_total++; if (locked !== 1'b0) $display("FAIL areset_locked: got %0b want 0", locked); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL areset_err: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (term_cnt !== 16'd0) $display("FAIL areset_term: got %0d want 0", term_cnt); else n_pass++;
    n_total++; if (sticky !== 1'b0) $display("FAIL areset_sticky: got %0b want 0", sticky); else n_pass++;
    n_total++; if (exp_v !== 32'd0) $display("FAIL areset_exp: got %0d want 0", exp_v); else n_pass++;
    #1 reset = 1'b0;
    drive(1'b1, pad32[0]);
    drive(1'b1, pad32[1]);
    n_total++; if (locked !== 1'b0) $display("FAIL areset_relock_early: got %0b want 0", locked); else n_pass++;
    drive(1'b1, pad32[2]);
    n_total++; if (locked !== 1'b1) $display("FAIL areset_relock: got %0b want 1", locked); else n_pass++;
    n_total++; if (err_cnt !== 16'd0) $display("FAIL areset_relock_err: got %0d want 0", err_cnt); else n_pass++;
    n_total++; if (term_cnt !== 16'd3) $display("FAIL areset_relock_term: got %0d want 3", term_cnt); else n_pass++;
    n_total++; if (exp_v !== 32'd1) $display("FAIL areset_relock_exp: got %0d want 1", exp_v); else n_pass++;
    drive(1'b0, 32'd0);
  endtask

  task automatic test_wrap8();
    int mm_seen;
    int exp_bad;
    int gap;
    mm_seen = 0;
    exp_bad = 0;
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge clk);
        vld8 = 1'b0;
      end
      @(negedge clk);
      vld8 = 1'b1;
      seq8 = pad8[i];
      @(posedge clk);
      #1;
      if (mism8 !== 1'b0) mm_seen++;
      if (i >= 2 && exp8 !== pad8[i+1]) exp_bad++;
    end
    @(negedge clk);
    vld8 = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (mm_seen != 0) $display("FAIL wrap8_mismatches: got %0d want 0", mm_seen); else n_pass++;
    n_total++; if (exp_bad != 0) $display("FAIL wrap8_exp_track: got %0d bad want 0", exp_bad); else n_pass++;
    n_total++; if (term8 !== 16'd200) $display("FAIL wrap8_term: got %0d want 200", term8); else n_pass++;
    n_total++; if (err8 !== 16'd0) $display("FAIL wrap8_err: got %0d want 0", err8); else n_pass++;
    n_total++; if (exp8 !== pad8[200]) $display("FAIL wrap8_exp_final: got %0d want %0d", exp8, pad8[200]); else n_pass++;
  endtask

  task automatic test_saturate();
    int missed;
    missed = 0;
    for (int i = 0; i < 23; i++) begin
      drive4(1'b1, (i < 3) ? pad32[i] : pad32[i] + 32'd1);
      if (i >= 3 && mism4 !== 1'b1) missed++;
    end
    n_total++; if (missed != 0) $display("FAIL sat_pulses: got %0d missed want 0", missed); else n_pass++;
    n_total++; if (err4 !== 4'd15) $display("FAIL sat_err_cnt: got %0d want 15", err4); else n_pass++;
    n_total++; if (term4 !== 4'd15) $display("FAIL sat_term_cnt: got %0d want 15", term4); else n_pass++;
    n_total++; if (idx4 !== 4'd3) $display("FAIL sat_first_idx: got %0d want 3", idx4); else n_pass++;
    n_total++; if (sticky4 !== 1'b1) $display("FAIL sat_sticky: got %0b want 1", sticky4); else n_pass++;
    drive4(1'b0, 32'd0);
    n_total++; if (mism4 !== 1'b0) $display("FAIL sat_idle_pulse: got %0b want 0", mism4); else n_pass++;
    @(negedge clk);
    clear4 = 1'b1;
    @(negedge clk);
    clear4 = 1'b0;
    for (int i = 0; i < 20; i++) drive4(1'b1, pad32[i]);
    n_total++; if (sticky4 !== 1'b0) $display("FAIL sat_clean_run: got %0b want 0", sticky4); else n_pass++;
    drive4(1'b1, pad32[20] + 32'd1);
    n_total++; if (mism4 !== 1'b1) $display("FAIL sat_late_pulse: got %0b want 1", mism4); else n_pass++;
    n_total++; if (idx4 !== 4'd15) $display("FAIL sat_late_idx: got %0d want 15", idx4); else n_pass++;
    n_total++; if (err4 !== 4'd1) $display("FAIL sat_late_err: got %0d want 1", err4); else n_pass++;
    drive4(1'b0, 32'd0);
  endtask

  initial begin
    pad32[0] = 32'(PAD_INIT0);
    pad32[1] = 32'(PAD_INIT1);
    pad32[2] = 32'(PAD_INIT2);
    for (int i = 3; i < 32; i++) pad32[i] = pad32[i-2] + pad32[i-3];
    pad8[0] = 8'(PAD_INIT0);
    pad8[1] = 8'(PAD_INIT1);
    pad8[2] = 8'(PAD_INIT2);
    for (int i = 3; i < 256; i++) pad8[i] = pad8[i-2] + pad8[i-3];

    test_reset();
    test_basic();
    test_corrupt();
    test_clear_with_beat();
    test_async_reset();
    test_wrap8();
    test_saturate();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_checker.md
# seq_checker

Downstream stream checker for the Padovan sequence generator. Consumes one 32-bit term per valid beat, acquires three terms of history, then independently predicts every following term (P(n) = P(n-2) + P(n-3), modulo 2^DW) and compares it with the received value. Reports lock status, per-beat mismatch pulses, a sticky error flag, saturating error and term counters, and the index of the first bad term. It sits on the generator output in self-test and bring-up builds.

## Interface
- DW, 32, data width of sequence terms
- CNT_W, 16, width of term/error counters and error index
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- clear_i  in  1  synchronous restart: drop history, zero counters and flags
- seq_vld_i  in  1  beat qualifier for seq_i
- seq_i  in  DW  received sequence term
- locked_o  out  1  history acquired, checking active
- mismatch_o  out  1  one-cycle pulse: last checked beat differed from prediction
- err_sticky_o  out  1  set on first mismatch, held until reset/clear
- err_cnt_o  out  CNT_W  mismatch count, saturating at all-ones
- term_cnt_o  out  CNT_W  accepted beats since reset/clear, saturating at all-ones
- first_err_idx_o  out  CNT_W  term index (0-based) of first mismatch; 0 while err_sticky_o low
- exp_o  out  DW  prediction for the next beat; 0 while locked_o low

## Operation
- FSM states: ACQ0, ACQ1, ACQ2, CHECK. Reset/clear → ACQ0.
- History registers h1 (newest), h2, h3; prediction exp = h2 + h3, truncated to DW bits (no carry out, no overflow flag).
- ACQ0/ACQ1/ACQ2: each beat shifts seq_i into h1 (h1→h2→h3), no compare; ACQ2 beat → CHECK.
- CHECK, beat: compare seq_i with exp. Match: shift seq_i in. Mismatch: pulse mismatch_o, err_cnt +1 (saturating), set err_sticky_o; if first error, latch term index into first_err_idx_o; shift in exp, not seq_i, so a single corrupted term counts once and does not cascade.
- Term index of a beat = term_cnt_o value before that beat increments. Index latch uses the pre-saturation value; saturated index stays all-ones.
- No beat (seq_vld_i low): all state held, mismatch_o low. Gaps of any length allowed.
- clear_i has priority over seq_vld_i in the same cycle; that beat is dropped (not counted, not stored).
- No backpressure: every valid beat is accepted.

## Timing
- All outputs registered. Reset values: locked_o 0, mismatch_o 0, err_sticky_o 0, err_cnt_o 0, term_cnt_o 0, first_err_idx_o 0, exp_o 0, history 0, state ACQ0.
- Beat at cycle N → term_cnt_o, mismatch_o, err_cnt_o, err_sticky_o, first_err_idx_o updated at N+1.
- locked_o rises at the cycle after the third accepted beat; exp_o valid from the same cycle and updates one cycle after each beat.
- mismatch_o width exactly one cycle per bad beat; back-to-back bad beats give back-to-back pulses.
- clear_i at cycle N → all outputs at reset values at N+1.
- Reset asserted mid-stream: immediate return to reset values, reacquisition required.

## Structure
- Package seq_pkg: state enum (ACQ0, ACQ1, ACQ2, CHECK), shared Padovan init constants (0, 1, 1) reused by generator and checker benches.
- Sub-module seq_term_calc: 3-deep DW-bit history shift register with shift-enable, load-select (received vs predicted) and combinational next-term adder h2 + h3. Checker top holds FSM, counters, index latch.

## Test plan
- Generator after reset drives 0,1,1,1,2,2,3,4,5,7 with continuous valid → locked_o high after 3rd beat, exp_o=1 then, no mismatch, term_cnt_o=10.
- Same stream, index 6 corrupted 3→8 → mismatch_o pulse the cycle after, err_cnt_o=1, first_err_idx_o=6, indices 7..9 (4,5,7) pass, err_cnt_o stays 1.
- DW=8 instance, 200 terms of the sequence mod 256 with random valid gaps → zero mismatches, term_cnt_o=200, exp_o wraps correctly.
- CNT_W=4, 20 consecutive corrupted beats in CHECK → err_cnt_o saturates at 15, first_err_idx_o = index of first bad beat, err_sticky_o stays high.
- clear_i asserted together with a valid beat mid-stream → beat dropped, all outputs zero next cycle, locked_o returns only after 3 new beats.
- Async reset pulsed between clock edges during CHECK → outputs zero immediately, relock after 3 beats with clean counters.
